// File: rtl/mc_pkg.sv
// Shared constants and request types for the pipelined memory controller.
package mc_pkg;

    // Default geometry of the controller
    localparam int unsigned MC_ADDR_W    = 16;
    localparam int unsigned MC_DATA_W    = 16;
    localparam int unsigned MC_MEM_WORDS = 1024;
    localparam int unsigned MC_Q_DEPTH   = 4;
    localparam int unsigned MC_RD_LAT    = 4;

    // Queue entry layouts at the default widths. The controller packs its
    // queue entries in the same field order ({addr, data} for writes).
    typedef struct packed {
        logic [MC_ADDR_W-1:0] addr;
        logic [MC_DATA_W-1:0] data;
    } wr_req_t;

    typedef struct packed {
        logic [MC_ADDR_W-1:0] addr;
    } rd_req_t;

    // Which channel owned the storage port most recently
    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_e;

endpackage

// File: rtl/mc_req_fifo.sv
// Request queue: power-of-two circular buffer that also exposes every slot
// and its valid flag so the owner can compare against all pending entries.
module mc_req_fifo
    import mc_pkg::*;
#(
    parameter int unsigned WIDTH = MC_ADDR_W,
    parameter int unsigned DEPTH = MC_Q_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0][WIDTH-1:0] entries,
    output logic [DEPTH-1:0]            entry_vld
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][WIDTH-1:0] slot_r;
    logic [DEPTH-1:0]            vld_r;
    logic [DEPTH-1:0]            vld_next_s;
    logic [PTR_W-1:0]            wr_ptr_r;
    logic [PTR_W-1:0]            rd_ptr_r;
    logic [CNT_W-1:0]            count_r;
    logic [CNT_W-1:0]            count_next_s;
    logic                        push_ok_s;
    logic                        pop_ok_s;

    // Fullness comes from registered occupancy only, so a push on a full
    // queue is refused even when the head leaves in the same cycle.
    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = slot_r[rd_ptr_r];
    assign entries   = slot_r;
    assign entry_vld = vld_r;

    // Next occupancy and slot-valid flags from this cycle's push/pop
    always_comb begin
        vld_next_s   = vld_r;
        count_next_s = count_r;
        if (pop_ok_s) begin
            vld_next_s[rd_ptr_r] = 1'b0;
        end else begin
            vld_next_s[rd_ptr_r] = vld_r[rd_ptr_r];
        end
        if (push_ok_s) begin
            vld_next_s[wr_ptr_r] = 1'b1;
        end else begin
            vld_next_s[wr_ptr_r] = vld_next_s[wr_ptr_r];
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Slot storage, wrapping pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r   <= '0;
            vld_r    <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                slot_r[wr_ptr_r] <= push_data;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            vld_r   <= vld_next_s;
            count_r <= count_next_s;
        end
    end

endmodule

// File: rtl/memory_controller_pipe.sv
// Memory controller with independent read/write request queues, a single
// storage port shared round-robin, read-after-write protection against all
// queued writes, and a fixed-latency read return pipeline.
module memory_controller_pipe
    import mc_pkg::*;
#(
    parameter int unsigned ADDR_W    = MC_ADDR_W,
    parameter int unsigned DATA_W    = MC_DATA_W,
    parameter int unsigned MEM_WORDS = MC_MEM_WORDS,
    parameter int unsigned Q_DEPTH   = MC_Q_DEPTH,
    parameter int unsigned RD_LAT    = MC_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_rdy,
    output logic              wr_ret_ack,
    output logic [ADDR_W-1:0] wr_ret_address,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_address,
    output logic              rd_rdy,
    output logic              rd_ret_ack,
    output logic [ADDR_W-1:0] rd_ret_address,
    output logic [DATA_W-1:0] rd_ret_data
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned WQ_W  = ADDR_W + DATA_W;

    // Write queue: entries are {addr, data}
    logic [WQ_W-1:0]                 wq_head_s;
    logic                            wq_full_s;
    logic                            wq_empty_s;
    logic [Q_DEPTH-1:0][WQ_W-1:0]    wq_ent_s;
    logic [Q_DEPTH-1:0]              wq_vld_s;
    logic [ADDR_W-1:0]               wq_head_addr_s;
    logic [DATA_W-1:0]               wq_head_data_s;

    // Read queue: entries are the address only
    logic [ADDR_W-1:0]               rq_head_s;
    logic                            rq_full_s;
    logic                            rq_empty_s;
    logic [Q_DEPTH-1:0][ADDR_W-1:0]  rq_ent_s;
    logic [Q_DEPTH-1:0]              rq_vld_s;

    // Arbitration
    logic   hazard_s;
    logic   wr_can_s;
    logic   rd_can_s;
    logic   grant_wr_s;
    logic   grant_rd_s;
    grant_e last_grant_r;

    // Storage and return registers
    logic [DATA_W-1:0]              mem_r [MEM_WORDS];
    logic                           wr_ack_r;
    logic [ADDR_W-1:0]              wr_tag_r;
    logic [RD_LAT-1:0]              rp_vld_r;
    logic [RD_LAT-1:0][ADDR_W-1:0]  rp_tag_r;
    logic [RD_LAT-1:0][DATA_W-1:0]  rp_data_r;

    // Read-queue slot contents are not needed; write-queue upper address
    // bits only travel as the tag.
    logic unused_slots_s;
    assign unused_slots_s = ^{rq_ent_s, rq_vld_s, wq_ent_s};

    mc_req_fifo #(
        .WIDTH (WQ_W),
        .DEPTH (Q_DEPTH)
    ) u_wr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data ({wr_address, wr_data}),
        .pop       (grant_wr_s),
        .head      (wq_head_s),
        .full      (wq_full_s),
        .empty     (wq_empty_s),
        .entries   (wq_ent_s),
        .entry_vld (wq_vld_s)
    );

    mc_req_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (Q_DEPTH)
    ) u_rd_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_en),
        .push_data (rd_address),
        .pop       (grant_rd_s),
        .head      (rq_head_s),
        .full      (rq_full_s),
        .empty     (rq_empty_s),
        .entries   (rq_ent_s),
        .entry_vld (rq_vld_s)
    );

    assign wq_head_addr_s = wq_head_s[WQ_W-1 -: ADDR_W];
    assign wq_head_data_s = wq_head_s[DATA_W-1:0];
    assign wr_rdy         = !wq_full_s;
    assign rd_rdy         = !rq_full_s;

    // Read head is held back while any queued write targets the same word
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < int'(Q_DEPTH); i++) begin
            hazard_s = hazard_s |
                       (wq_vld_s[i] &&
                        (wq_ent_s[i][DATA_W +: IDX_W] == rq_head_s[IDX_W-1:0]));
        end
    end

    // Pick one issuing head per cycle; ties alternate from the last grant
    always_comb begin
        wr_can_s   = !wq_empty_s;
        rd_can_s   = !rq_empty_s && !hazard_s;
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
        if (wr_can_s && rd_can_s) begin
            if (last_grant_r == GRANT_RD) begin
                grant_wr_s = 1'b1;
            end else begin
                grant_rd_s = 1'b1;
            end
        end else if (wr_can_s) begin
            grant_wr_s = 1'b1;
        end else if (rd_can_s) begin
            grant_rd_s = 1'b1;
        end else begin
            grant_wr_s = 1'b0;
            grant_rd_s = 1'b0;
        end
    end

    // Remember the last granted channel for round-robin tie breaks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= GRANT_RD;
        end else if (grant_wr_s) begin
            last_grant_r <= GRANT_WR;
        end else if (grant_rd_s) begin
            last_grant_r <= GRANT_RD;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (grant_wr_s) begin
            mem_r[wq_head_addr_s[IDX_W-1:0]] <= wq_head_data_s;
        end
    end

    // Write completion: one-cycle ack, tag holds between acks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_r <= 1'b0;
            wr_tag_r <= '0;
        end else begin
            wr_ack_r <= grant_wr_s;
            if (grant_wr_s) begin
                wr_tag_r <= wq_head_addr_s;
            end
        end
    end

    // Read return pipeline; tag/data stages only move with a valid so the
    // last stage holds the most recent return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_vld_r  <= '0;
            rp_tag_r  <= '0;
            rp_data_r <= '0;
        end else begin
            rp_vld_r[0] <= grant_rd_s;
            if (grant_rd_s) begin
                rp_tag_r[0]  <= rq_head_s;
                rp_data_r[0] <= mem_r[rq_head_s[IDX_W-1:0]];
            end
            for (int s = 1; s < int'(RD_LAT); s++) begin
                rp_vld_r[s] <= rp_vld_r[s-1];
                if (rp_vld_r[s-1]) begin
                    rp_tag_r[s]  <= rp_tag_r[s-1];
                    rp_data_r[s] <= rp_data_r[s-1];
                end
            end
        end
    end

    assign wr_ret_ack     = wr_ack_r;
    assign wr_ret_address = wr_tag_r;
    assign rd_ret_ack     = rp_vld_r[RD_LAT-1];
    assign rd_ret_address = rp_tag_r[RD_LAT-1];
    assign rd_ret_data    = rp_data_r[RD_LAT-1];

endmodule

// File: tb/tb_memory_controller_pipe.sv
// Bench for memory_controller_pipe: queue-level reference model checked on
// every falling edge, plus directed scenarios with hand-computed results.
`timescale 1ns/1ps
module tb_memory_controller_pipe;
    import mc_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 1024;
    localparam int QD = 4;
    localparam int RL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en, rd_en, wr_rdy, rd_rdy, wr_ret_ack, rd_ret_ack;
    logic [AW-1:0] wr_address, rd_address, wr_ret_address, rd_ret_address;
    logic [DW-1:0] wr_data, rd_ret_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_controller_pipe #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .Q_DEPTH(QD), .RD_LAT(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .wr_ret_ack(wr_ret_ack), .wr_ret_address(wr_ret_address),
        .rd_en(rd_en), .rd_address(rd_address), .rd_rdy(rd_rdy),
        .rd_ret_ack(rd_ret_ack), .rd_ret_address(rd_ret_address), .rd_ret_data(rd_ret_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [AW-1:0] tag;
        logic [DW-1:0] data;
        bit            known;
    } ret_t;

    wr_req_t       m_wq[$];
    logic [AW-1:0] m_rq[$];
    ret_t          m_pend[$];
    logic [DW-1:0] m_mem[int];
    bit            m_last_wr = 1'b0;
    int            m_edge = 0;
    logic          m_wr_ack = 1'b0, m_rd_ack = 1'b0;
    logic [AW-1:0] m_wr_tag = '0, m_rd_tag = '0;
    logic [DW-1:0] m_rd_data = '0;
    bit            m_rd_known = 1'b1;

    // Model: advance queues, storage and return schedule at each clock edge
    always @(posedge clk or negedge rst_n) begin
        bit      wr_ok, rd_ok, haz, can_w, can_r, do_w, do_r;
        wr_req_t w;
        ret_t    r;
        if (!rst_n) begin
            m_wq.delete(); m_rq.delete(); m_pend.delete();
            m_last_wr = 1'b0; m_wr_ack = 1'b0; m_rd_ack = 1'b0;
            m_wr_tag = '0; m_rd_tag = '0; m_rd_data = '0; m_rd_known = 1'b1;
        end else begin
            m_edge++;
            wr_ok = wr_en && (m_wq.size() < QD);
            rd_ok = rd_en && (m_rq.size() < QD);
            haz = 1'b0;
            if (m_rq.size() > 0)
                foreach (m_wq[i])
                    if ((int'(m_wq[i].addr) % MW) == (int'(m_rq[0]) % MW)) haz = 1'b1;
            can_w = (m_wq.size() > 0);
            can_r = (m_rq.size() > 0) && !haz;
            do_w  = (can_w && can_r) ? !m_last_wr : can_w;
            do_r  = can_r && !do_w;
            m_wr_ack = 1'b0;
            if (do_w) begin
                w = m_wq.pop_front();
                m_mem[int'(w.addr) % MW] = w.data;
                m_wr_ack = 1'b1; m_wr_tag = w.addr; m_last_wr = 1'b1;
            end
            if (do_r) begin
                r.tag   = m_rq.pop_front();
                r.due   = m_edge + RL - 1;
                r.known = m_mem.exists(int'(r.tag) % MW);
                r.data  = r.known ? m_mem[int'(r.tag) % MW] : '0;
                m_pend.push_back(r);
                m_last_wr = 1'b0;
            end
            if (wr_ok) begin
                w.addr = wr_address; w.data = wr_data;
                m_wq.push_back(w);
            end
            if (rd_ok) m_rq.push_back(rd_address);
            m_rd_ack = 1'b0;
            if (m_pend.size() > 0 && m_pend[0].due == m_edge) begin
                r = m_pend.pop_front();
                m_rd_ack = 1'b1; m_rd_tag = r.tag; m_rd_data = r.data; m_rd_known = r.known;
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        chk("wr_rdy", wr_rdy, (m_wq.size() < QD));
        chk("rd_rdy", rd_rdy, (m_rq.size() < QD));
        chk("wr_ret_ack", wr_ret_ack, m_wr_ack);
        chk("wr_ret_address", wr_ret_address, m_wr_tag);
        chk("rd_ret_ack", rd_ret_ack, m_rd_ack);
        chk("rd_ret_address", rd_ret_address, m_rd_tag);
        if (m_rd_known) chk("rd_ret_data", rd_ret_data, m_rd_data);
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_acks(input int max_cyc, output int wl, output int rl,
                             output logic [AW-1:0] rtag, output logic [DW-1:0] rdat);
        wl = 0; rl = 0; rtag = '0; rdat = '0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (wr_ret_ack && wl == 0) wl = k;
            if (rd_ret_ack && rl == 0) begin
                rl = k; rtag = rd_ret_address; rdat = rd_ret_data;
            end
            if (k < max_cyc) @(negedge clk);
        end
    endtask

    task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit re, input logic [AW-1:0] ra);
        wr_en = we; wr_address = wa; wr_data = wd;
        rd_en = re; rd_address = ra;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        int            wl, rl, wi, ri, wc, rc, nret;
        bit            alt_ok, prev;
        logic [AW-1:0] rtag;
        logic [DW-1:0] rdat;
        logic [AW-1:0] tags[8];
        logic [DW-1:0] dats[8];

        wr_en = 1'b0; rd_en = 1'b0; wr_address = '0; wr_data = '0; rd_address = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_wr_rdy", wr_rdy, 1'b1);
        chk("reset_rd_rdy", rd_rdy, 1'b1);
        chk("reset_rd_data", rd_ret_data, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read the same word
        drive(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
        wait_acks(8, wl, rl, rtag, rdat);
        chk("t1_wr_latency", wl, 2);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010);
        wait_acks(10, wl, rl, rtag, rdat);
        chk("t1_rd_latency", rl, 5);
        chk("t1_rd_tag", rtag, 16'h0010);
        chk("t1_rd_data", rdat, 16'hBEEF);

        // Same-cycle write and read to one word: write goes first
        drive(1'b1, 16'h0020, 16'h1234, 1'b1, 16'h0020);
        wait_acks(12, wl, rl, rtag, rdat);
        chk("t2_wr_latency", wl, 2);
        chk("t2_rd_latency", rl, 6);
        chk("t2_rd_data", rdat, 16'h1234);

        // Fill 0x100..0x10F and 0x200..0x20F with known data
        for (int i = 0; i < 16; i++) drive(1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 1'b0, 16'h0000);
        for (int i = 0; i < 16; i++) drive(1'b1, 16'h0200 + 16'(i), 16'hC000 + 16'(i), 1'b0, 16'h0000);
        repeat (4) @(negedge clk);

        // Both queues streaming distinct addresses: grants alternate
        wi = 0; ri = 0; wc = 0; rc = 0; alt_ok = 1'b1; prev = 1'b0;
        for (int c = 0; c < 48; c++) begin
            if (c >= 10 && c < 18) begin
                wc += int'(wr_ret_ack); rc += int'(rd_ret_ack);
                if (c > 10 && wr_ret_ack == prev) alt_ok = 1'b0;
                prev = wr_ret_ack;
            end
            wr_en = (wi < 16) && wr_rdy; wr_address = 16'h0300 + 16'(wi); wr_data = 16'h7000 + 16'(wi);
            if (wr_en) wi++;
            rd_en = (ri < 16) && rd_rdy; rd_address = 16'h0100 + 16'(ri);
            if (rd_en) ri++;
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk("t3_wr_acks_in_8", wc, 4);
        chk("t3_rd_acks_in_8", rc, 4);
        chk("t3_wr_alternates", alt_ok, 1'b1);
        repeat (10) @(negedge clk);

        // Read queue saturates behind a blocking write stream; fifth read dropped
        nret = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 4) chk("t4_rd_rdy_full", rd_rdy, 1'b0);
            if (rd_ret_ack && nret < 8) begin
                tags[nret] = rd_ret_address; dats[nret] = rd_ret_data; nret++;
            end
            wr_en = (c < 8); wr_address = 16'h0200; wr_data = 16'h5000 + 16'(c);
            rd_en = (c < 5); rd_address = 16'h0200 + 16'(c);
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk("t4_return_count", nret, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t4_tag%0d", k), tags[k], 16'h0200 + 16'(k));
        chk("t4_data0", dats[0], 16'h5007);
        chk("t4_data1", dats[1], 16'hC001);
        chk("t4_data3", dats[3], 16'hC003);

        // Upper address bits alias storage but return unchanged as tag
        drive(1'b1, 16'h0010, 16'h00AA, 1'b0, 16'h0000);
        wait_acks(8, wl, rl, rtag, rdat);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0410);
        wait_acks(10, wl, rl, rtag, rdat);
        chk("t5_rd_latency", rl, 5);
        chk("t5_rd_tag", rtag, 16'h0410);
        chk("t5_rd_data", rdat, 16'h00AA);

        // Reset with reads in flight and writes queued: nothing comes back
        for (int c = 0; c < 4; c++) begin
            rd_en = (c < 3); rd_address = 16'h0100 + 16'(c);
            wr_en = (c >= 2); wr_address = 16'h0400 + 16'(c); wr_data = 16'h9000 + 16'(c);
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_rd_ack", rd_ret_ack, 1'b0);
        chk("t6_rst_rd_data", rd_ret_data, 16'h0000);
        chk("t6_rst_rd_tag", rd_ret_address, 16'h0000);
        chk("t6_rst_wr_tag", wr_ret_address, 16'h0000);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            wc += int'(wr_ret_ack) + int'(rd_ret_ack);
        end
        chk("t6_acks_after_release", wc, 0);
        chk("t6_rd_rdy", rd_rdy, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
